// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one synchronous single-port memory between the MIPS instruction-fetch
// port (read-only) and the data port (read/write). Each access runs through a
// fixed-latency sequence IDLE -> ISSUE -> WAIT -> RESP. Results return on a
// one-cycle ack. Data requests win arbitration. A streak limit forces a fetch
// grant after MAX_STREAK consecutive data grants made while fetch was waiting.
//
// Build option: define MEM_ARB_PERF_EN to add the if_wait_cnt/dm_wait_cnt
// per-port wait-cycle counters.
//
// state | meaning
// IDLE  | sample requests, pick winner, latch address/we/wdata
// ISSUE | mem_en high for exactly one cycle
// WAIT  | count down memory latency, capture read data on the last cycle
// RESP  | winner's ack high for one cycle
module mips_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]   if_wait_cnt,
  output logic [31:0]   dm_wait_cnt,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT lasts LAT-1 cycles; the counter holds the WAIT cycles left after the
  // current one, so it is loaded with LAT-2 and the capture happens at zero.
  localparam logic [3:0] WAIT_LOAD  = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic [3:0]    streak, streak_nxt;
  logic          sel_dm, sel_dm_nxt;
  logic          mem_en_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          if_ack_nxt, dm_ack_nxt;
  logic [DW-1:0] if_rdata_nxt, dm_rdata_nxt;
  logic          busy_nxt;
  logic          grant_dm;
  logic          done;

  // Data wins unless fetch is waiting and the data streak has hit its limit.
  assign grant_dm = dm_req && !(if_req && (streak == STREAK_MAX));

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      streak    <= 4'd0;
      sel_dm    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      streak    <= streak_nxt;
      sel_dm    <= sel_dm_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_ack    <= if_ack_nxt;
      dm_ack    <= dm_ack_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    streak_nxt    = streak;
    sel_dm_nxt    = sel_dm;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_ack_nxt    = 1'b0;
    dm_ack_nxt    = 1'b0;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          state_nxt  = ISSUE;
          mem_en_nxt = 1'b1;
          if (grant_dm) begin
            sel_dm_nxt    = 1'b1;
            mem_addr_nxt  = dm_addr;
            mem_we_nxt    = dm_we;
            mem_wdata_nxt = dm_wdata;
            // Only grants that make a waiting fetch wait longer count.
            if (if_req)
              streak_nxt = (streak == STREAK_MAX) ? streak : streak + 4'd1;
            else
              streak_nxt = 4'd0;
          end else begin
            sel_dm_nxt   = 1'b0;
            mem_addr_nxt = if_addr;
            mem_we_nxt   = 1'b0;
            streak_nxt   = 4'd0;
          end
        end
      end
      ISSUE: begin
        // With single-cycle latency the data is already valid here.
        if (LAT == 1) begin
          done = 1'b1;
        end else begin
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0)
          done = 1'b1;
        else
          wait_cnt_nxt = wait_cnt - 4'd1;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (done) begin
      state_nxt  = RESP;
      if_ack_nxt = !sel_dm;
      dm_ack_nxt = sel_dm;
      if (!mem_we) begin
        if (sel_dm)
          dm_rdata_nxt = mem_rdata;
        else
          if_rdata_nxt = mem_rdata;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef MEM_ARB_PERF_EN
  // Per-port cycles spent waiting for an ack; free-running, wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_cnt <= 32'd0;
      dm_wait_cnt <= 32'd0;
    end else begin
      if (if_req && !if_ack)
        if_wait_cnt <= if_wait_cnt + 32'd1;
      if (dm_req && !dm_ack)
        dm_wait_cnt <= dm_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios followed by randomized
// traffic on both ports, checked cycle by cycle against a transaction-level
// reference model (arbitration rule, fixed transaction length, reference memory).
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int LAT        = 2;
  localparam int MAX_STREAK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 32'hBAD0_BAD0;
  logic          busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   if_wait_cnt, dm_wait_cnt;
`endif

  mips_mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
    .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory device: read data is valid from the cycle after mem_en until the
  // arbiter goes idle again; junk otherwise, so early or late sampling shows.
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
    else if (!busy)
      mem_rdata <= 32'hBAD0_BAD0;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            tx_left = 0;
  int            streak = 0;
  bit            win_dm = 1'b0;
  bit            exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wd = '0, exp_rd = '0;
  logic [DW-1:0] exp_if_rdata = '0, exp_dm_rdata = '0;
  logic [31:0]   exp_if_wait = '0, exp_dm_wait = '0;
  bit            rnd_mode = 1'b0, dm_stream = 1'b0;
  bit            inj_if = 1'b0, inj_dm = 1'b0, inj_dm_we = 1'b0;
  logic [AW-1:0] inj_if_addr = '0, inj_dm_addr = '0;
  logic [DW-1:0] inj_dm_wdata = '0;
  int            last_en_cyc = -1, last_if_ack_cyc = -1, last_dm_ack_cyc = -1;
  bit            ack_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {if_ack, dm_ack, mem_en, mem_we, busy}, '0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, '0);
    chk({tag, "_rdata"}, {if_rdata, dm_rdata}, '0);
  endtask

  task automatic model_reset();
    tx_left = 0; streak = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    exp_if_wait = '0; exp_dm_wait = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'({$urandom_range(15), 2'b00});
  endfunction

  task automatic new_dm();
    dm_req = 1'b1; dm_we = 1'($urandom_range(1));
    dm_addr = rnd_addr(); dm_wdata = $urandom;
  endtask

  // One clock cycle: check outputs against the model, then drive requesters,
  // then let the model take its arbitration decision if the arbiter is idle.
  task automatic cycle();
    int k;
    bit e_en, e_ifa, e_dma, s_ifa, s_dma;
    @(negedge clk);
    cyc++;
    k = (tx_left == 0) ? 0 : (LAT + 2 - tx_left);
    e_en  = (k == 1);
    e_ifa = (k == LAT + 1) && !win_dm;
    e_dma = (k == LAT + 1) && win_dm;
    if (e_ifa) exp_if_rdata = exp_rd;
    if (e_dma && !exp_we) exp_dm_rdata = exp_rd;
    chk("ctrl{en,if_ack,dm_ack,busy}", {mem_en, if_ack, dm_ack, busy},
        {e_en, e_ifa, e_dma, k != 0});
    if (e_en) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", mem_we, exp_we);
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
    end
    chk("rdata{if,dm}", {if_rdata, dm_rdata}, {exp_if_rdata, exp_dm_rdata});
`ifdef MEM_ARB_PERF_EN
    chk("wait_cnt{if,dm}", {if_wait_cnt, dm_wait_cnt}, {exp_if_wait, exp_dm_wait});
`endif
    s_ifa = if_ack; s_dma = dm_ack;
    if (mem_en) last_en_cyc = cyc;
    if (s_ifa) begin last_if_ack_cyc = cyc; ack_log.push_back(1'b0); end
    if (s_dma) begin last_dm_ack_cyc = cyc; ack_log.push_back(1'b1); end
    if (tx_left > 0) tx_left--;

    if (s_ifa) begin
      if (rnd_mode && $urandom_range(1) == 1) if_addr = rnd_addr();
      else if_req = 1'b0;
    end else if (inj_if) begin
      if_req = 1'b1; if_addr = inj_if_addr; inj_if = 1'b0;
    end else if (!if_req && rnd_mode && $urandom_range(3) == 0) begin
      if_req = 1'b1; if_addr = rnd_addr();
    end

    if (s_dma) begin
      if (dm_stream || (rnd_mode && $urandom_range(1) == 1)) new_dm();
      else dm_req = 1'b0;
    end else if (inj_dm) begin
      dm_req = 1'b1; dm_we = inj_dm_we; dm_addr = inj_dm_addr; dm_wdata = inj_dm_wdata;
      inj_dm = 1'b0;
    end else if (!dm_req && rnd_mode && $urandom_range(3) == 0) begin
      new_dm();
    end

    if (if_req && !s_ifa) exp_if_wait++;
    if (dm_req && !s_dma) exp_dm_wait++;

    if (k == 0 && (if_req || dm_req)) begin
      win_dm = dm_req && !(if_req && streak == MAX_STREAK);
      if (win_dm) begin
        streak   = if_req ? ((streak < MAX_STREAK) ? streak + 1 : MAX_STREAK) : 0;
        exp_addr = dm_addr; exp_we = dm_we; exp_wd = dm_wdata;
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
      end else begin
        streak = 0; exp_addr = if_addr; exp_we = 1'b0;
      end
      exp_rd  = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : dflt(exp_addr);
      tx_left = LAT + 1;
    end
  endtask

  initial begin
    int t0;
    logic [5:0] pat;

    dev_mem[32'h4]   = 32'h8C22_0000; ref_mem[32'h4]   = 32'h8C22_0000;
    dev_mem[32'h200] = 32'h1234_5678; ref_mem[32'h200] = 32'h1234_5678;

    // Reset state
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_hold");
    @(negedge clk) rst = 1'b0;
    repeat (3) cycle();

    // Single fetch
    inj_if = 1'b1; inj_if_addr = 32'h4;
    cycle(); t0 = cyc;
    repeat (5) cycle();
    chk("t1_en_cycle", 64'(last_en_cyc - t0), 64'd1);
    chk("t1_ack_cycle", 64'(last_if_ack_cyc - t0), 64'd3);
    chk("t1_if_rdata", if_rdata, 32'h8C22_0000);
`ifdef MEM_ARB_PERF_EN
    chk("t1_if_wait_cnt", if_wait_cnt, 32'd3);
    chk("t1_dm_wait_cnt", dm_wait_cnt, 32'd0);
`endif

    // Data write
    inj_dm = 1'b1; inj_dm_we = 1'b1; inj_dm_addr = 32'h100; inj_dm_wdata = 32'hDEAD_BEEF;
    cycle(); t0 = cyc;
    repeat (5) cycle();
    chk("t2_ack_cycle", 64'(last_dm_ack_cyc - t0), 64'd3);
    chk("t2_dm_rdata_kept", dm_rdata, 32'h0);
    chk("t2_mem_written", dev_mem.exists(32'h100) ? dev_mem[32'h100] : 32'h0, 32'hDEAD_BEEF);

    // Simultaneous fetch and data read
    inj_dm = 1'b1; inj_dm_we = 1'b0; inj_dm_addr = 32'h200; inj_dm_wdata = 32'h0;
    inj_if = 1'b1; inj_if_addr = 32'h8;
    cycle(); t0 = cyc;
    repeat (9) cycle();
    chk("t3_dm_ack_cycle", 64'(last_dm_ack_cyc - t0), 64'd3);
    chk("t3_dm_rdata", dm_rdata, 32'h1234_5678);
    chk("t3_if_en_cycle", 64'(last_en_cyc - t0), 64'd5);
    chk("t3_if_ack_cycle", 64'(last_if_ack_cyc - t0), 64'd7);

    // Starvation guard: data streams, fetch held
    ack_log.delete();
    inj_if = 1'b1; inj_if_addr = 32'hC;
    inj_dm = 1'b1; inj_dm_we = 1'b0; inj_dm_addr = 32'h20; inj_dm_wdata = 32'h0;
    dm_stream = 1'b1;
    repeat (6 * (LAT + 2)) cycle();
    dm_stream = 1'b0;
    repeat (12) cycle();
    pat = '0;
    for (int i = 0; i < 6; i++)
      pat = {pat[4:0], (i < ack_log.size()) ? ack_log[i] : 1'b0};
    chk("t4_ack_order", pat, 6'b111101);

    // Reset during WAIT, then re-request
    inj_if = 1'b1; inj_if_addr = 32'h10;
    repeat (3) cycle();
    rst = 1'b1; if_req = 1'b0;
    #1 chk_reset("t5_async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_no_ack", {if_ack, dm_ack, busy, mem_en}, '0);
    rst = 1'b0;
    inj_if = 1'b1; inj_if_addr = 32'h10;
    cycle(); t0 = cyc;
    repeat (5) cycle();
    chk("t5_ack_cycle", 64'(last_if_ack_cyc - t0), 64'd3);
    chk("t5_if_rdata", if_rdata, dflt(32'h10));

    // Randomized traffic on both ports
    rnd_mode = 1'b1;
    repeat (800) cycle();
    rnd_mode = 1'b0;
    repeat (20) cycle();
    chk("final_idle", {busy, if_req, dm_req}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
